// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment frame driver.
package seg_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_frame_driver.sv
// Double-buffered 4-digit common-anode 7-seg driver with scan-wrap frame swap
// and anti-ghost guard. SEG_ZERO_BLANK_EN enables leading-zero blanking.
module seg_frame_driver
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  digit_sel,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [15:0] frame_data,
  input  logic [3:0]  frame_dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_swap
);
  localparam int GW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [15:0] pend_data, act_data;
  logic [3:0]  pend_dp, act_dp;
  logic        pend_full;
  digit_idx_t  prev_sel;
  logic [GW-1:0] guard, guard_nxt;
  logic        accept, wrap, change;

  assign frame_ready = ~pend_full;
  assign accept      = frame_valid & ~pend_full;
  assign wrap        = (prev_sel == 2'd3) && (digit_sel == 2'd0);
  assign change      = (prev_sel != digit_sel);

  // Swap only when pending is full, accept only when empty: mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      frame_swap <= 1'b0;
    end else begin
      frame_swap <= 1'b0;
      if (wrap && pend_full) begin
        act_data   <= pend_data;
        act_dp     <= pend_dp;
        pend_full  <= 1'b0;
        frame_swap <= 1'b1;
      end else if (accept) begin
        pend_data <= frame_data;
        pend_dp   <= frame_dp;
        pend_full <= 1'b1;
      end
    end
  end

  always_comb begin
    guard_nxt = '0;
    if (change)           guard_nxt = GW'(BLANK_CYCLES);
    else if (guard != '0) guard_nxt = guard - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel <= '0;
      guard    <= '0;
    end else begin
      prev_sel <= digit_sel;
      guard    <= guard_nxt;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] dec;
  logic [NUM_DIGITS-1:0]      zblank;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decoder u_dec (.nib(act_data[4*g +: 4]), .seg(dec[g]));
  end

`ifdef SEG_ZERO_BLANK_EN
  // Digit k blanks when it and all higher digits are zero with no dp lit.
  always_comb begin
    zblank = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      zblank[k] = ((act_data >> (4 * k)) == 16'h0) && ((act_dp >> k) == 4'h0);
  end
`else
  assign zblank = '0;
`endif

  // Guard uses its next value so the first output cycle after a change is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= (guard_nxt != '0) ? AN_OFF : ~(4'b0001 << digit_sel);
      seg <= zblank[digit_sel] ? SEG_BLANK : dec[digit_sel];
      dp  <= ~act_dp[digit_sel];
    end
  end
endmodule

// File: tb/tb_seg_frame_driver.sv
// Directed self-checking bench for seg_frame_driver (default BLANK_CYCLES=2).
module tb_seg_frame_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  digit_sel = 2'd0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [15:0] frame_data = 16'h0;
  logic [3:0]  frame_dp = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_swap;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg_frame_driver dut (
    .clk(clk), .rst_n(rst_n), .digit_sel(digit_sel),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_dp(frame_dp),
    .an(an), .seg(seg), .dp(dp), .frame_swap(frame_swap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got=%h want=F", an); end
    n_chk++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%h want=7F", seg); end
    n_chk++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b want=1", dp); end
    n_chk++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", frame_ready); end
    n_chk++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL reset_swap got=%b want=0", frame_swap); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (an !== 4'hE) begin n_fail++; $display("FAIL release_an got=%h want=E", an); end
    n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL release_seg got=%h want=40", seg); end
  endtask

  task automatic test_scan_empty();
    int d;
    for (int i = 0; i < 4; i++) begin
      d = (i + 1) % 4;
      digit_sel = 2'(d);
      tick();
      n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL scan_guard1 d=%0d got=%h want=F", d, an); end
      n_chk++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL scan_noswap d=%0d got=%b want=0", d, frame_swap); end
      tick();
      n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL scan_guard2 d=%0d got=%h want=F", d, an); end
      tick();
      n_chk++; if (an !== an_tab[d]) begin n_fail++; $display("FAIL scan_an d=%0d got=%h want=%h", d, an, an_tab[d]); end
      n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL scan_seg d=%0d got=%h want=40", d, seg); end
      n_chk++; if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp d=%0d got=%b want=1", d, dp); end
      repeat (7) tick();
    end
  endtask

  task automatic test_frame_swap();
    logic [6:0] exp_seg [4] = '{7'h79, 7'h0E, 7'h30, 7'h08};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    digit_sel = 2'd1;
    repeat (4) tick();
    frame_valid = 1'b1; frame_data = 16'hA3F1; frame_dp = 4'b0100;
    tick();
    frame_valid = 1'b0;
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL frame_ready_low got=%b want=0", frame_ready); end
    for (int d = 2; d < 4; d++) begin
      digit_sel = 2'(d);
      repeat (3) tick();
      n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL frame_held d=%0d got=%h want=40", d, seg); end
      repeat (7) tick();
    end
    digit_sel = 2'd0;
    tick();
    n_chk++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL frame_swap_pulse got=%b want=1", frame_swap); end
    n_chk++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready_back got=%b want=1", frame_ready); end
    tick();
    n_chk++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL frame_swap_1clk got=%b want=0", frame_swap); end
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        digit_sel = 2'(d);
        tick(); tick();
      end
      tick();
      n_chk++; if (an !== an_tab[d]) begin n_fail++; $display("FAIL frame_an d=%0d got=%h want=%h", d, an, an_tab[d]); end
      n_chk++; if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL frame_seg d=%0d got=%h want=%h", d, seg, exp_seg[d]); end
      n_chk++; if (dp !== exp_dp[d]) begin n_fail++; $display("FAIL frame_dp d=%0d got=%b want=%b", d, dp, exp_dp[d]); end
      repeat (7) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seg_a [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] seg_b [4] = '{7'h00, 7'h78, 7'h02, 7'h12};
    logic       dp_b  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    frame_valid = 1'b1; frame_data = 16'h1234; frame_dp = 4'h0;
    tick();
    frame_data = 16'h5678; frame_dp = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held i=%0d got=%b want=0", i, frame_ready); end
      tick();
    end
    digit_sel = 2'd0;
    tick();
    n_chk++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL b2b_swap1 got=%b want=1", frame_swap); end
    n_chk++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_swap got=%b want=1", frame_ready); end
    tick();
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got=%b want=0", frame_ready); end
    frame_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        digit_sel = 2'(d);
        tick();
      end
      tick();
      n_chk++; if (seg !== seg_a[d]) begin n_fail++; $display("FAIL b2b_first_seg d=%0d got=%h want=%h", d, seg, seg_a[d]); end
      repeat (7) tick();
    end
    digit_sel = 2'd0;
    tick();
    n_chk++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL b2b_swap2 got=%b want=1", frame_swap); end
    tick();
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        digit_sel = 2'(d);
        tick(); tick();
      end
      tick();
      n_chk++; if (seg !== seg_b[d]) begin n_fail++; $display("FAIL b2b_second_seg d=%0d got=%h want=%h", d, seg, seg_b[d]); end
      n_chk++; if (dp !== dp_b[d]) begin n_fail++; $display("FAIL b2b_second_dp d=%0d got=%b want=%b", d, dp, dp_b[d]); end
      repeat (7) tick();
    end
  endtask

  task automatic test_accept_on_wrap();
    digit_sel = 2'd0;
    frame_valid = 1'b1; frame_data = 16'h0050; frame_dp = 4'h0;
    tick();
    frame_valid = 1'b0;
    n_chk++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL wrap_accept_noswap got=%b want=0", frame_swap); end
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_accept_ready got=%b want=0", frame_ready); end
    tick(); tick();
    n_chk++; if (seg !== 7'h00) begin n_fail++; $display("FAIL wrap_old_frame got=%h want=00", seg); end
    repeat (7) tick();
    for (int d = 1; d < 4; d++) begin
      digit_sel = 2'(d);
      repeat (10) tick();
    end
    digit_sel = 2'd0;
    tick();
    n_chk++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL wrap_next_swap got=%b want=1", frame_swap); end
    tick();
  endtask

  task automatic test_zero_blank();
`ifdef SEG_ZERO_BLANK_EN
    logic [6:0] exp_seg [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
    logic [6:0] exp_seg [4] = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        digit_sel = 2'(d);
        tick(); tick();
      end
      tick();
      n_chk++; if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL zblank_seg d=%0d got=%h want=%h", d, seg, exp_seg[d]); end
      n_chk++; if (an !== an_tab[d]) begin n_fail++; $display("FAIL zblank_an d=%0d got=%h want=%h", d, an, an_tab[d]); end
      repeat (7) tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_valid = 1'b1; frame_data = 16'hFFFF; frame_dp = 4'hF;
    tick();
    frame_valid = 1'b0;
    n_chk++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got=%b want=0", frame_ready); end
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL rstmid_an got=%h want=F", an); end
    n_chk++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rstmid_seg got=%h want=7F", seg); end
    n_chk++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b want=1", frame_ready); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    digit_sel = 2'd0;
    tick();
    n_chk++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard got=%b want=0", frame_swap); end
    tick(); tick();
    n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL rstmid_active_seg got=%h want=40", seg); end
    n_chk++; if (dp !== 1'b1) begin n_fail++; $display("FAIL rstmid_active_dp got=%b want=1", dp); end
  endtask

  initial begin
    test_reset();
    test_scan_empty();
    test_frame_swap();
    test_back_to_back();
    test_accept_on_wrap();
    test_zero_blank();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
